// File: rtl/dma_engine.sv
// Single-channel memory-to-memory DMA: CPU-programmed SRC/DST/LEN, word copy over a
// granted master port, two bus cycles (read then write) per word.
module dma_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] dma_data_out,
    output logic        m_req,
    input  logic        m_gnt,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,
    output logic        irq
);

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [LW-1:0]   len_q;
    logic [AW-1:0]   src_p;
    logic [AW-1:0]   dst_p;
    logic [LW-1:0]   cnt;
    logic [31:0]     buffer;
    logic            done;
    logic            err;

    logic            busy;
    logic            ctrl_wr;
    logic            go;
    logic            clr;
    logic            misaligned;

    assign busy       = (state != S_IDLE);
    assign ctrl_wr    = WE && (A == REG_CTRL);
    assign go         = ctrl_wr && WD[0] && !busy;
    assign clr        = ctrl_wr && WD[1];
    assign misaligned = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);
    assign irq        = done;

    // CPU register read-back; SRC/DST show programmed values, never the working pointers
    always_comb begin
        dma_data_out = '0;
        case (A)
            REG_SRC:  dma_data_out = src_q;
            REG_DST:  dma_data_out = dst_q;
            REG_LEN:  dma_data_out = 32'(len_q);
            REG_CTRL: dma_data_out = {29'b0, err, done, busy};
            default:  dma_data_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and master-port drive; a grant drop stalls RD back to REQ and freezes WR
    always_comb begin
        state_next = state;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wd       = '0;
        case (state)
            S_IDLE: begin
                if (go && !misaligned) begin
                    state_next = (len_q == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                m_req      = 1'b1;
                m_addr     = src_p;
                state_next = m_gnt ? S_WR : S_REQ;
            end
            S_WR: begin
                m_req  = 1'b1;
                m_addr = dst_p;
                m_wd   = buffer;
                m_we   = m_gnt;
                if (m_gnt) begin
                    state_next = (cnt == LW'(1)) ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Registers and datapath; FIN's done-set is last so it wins over a same-cycle clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            src_p  <= '0;
            dst_p  <= '0;
            cnt    <= '0;
            buffer <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (WE && !busy) begin
                case (A)
                    REG_SRC: src_q <= WD;
                    REG_DST: dst_q <= WD;
                    REG_LEN: len_q <= WD[LW-1:0];
                    default: ;
                endcase
            end
            if (clr) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (misaligned) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else if (len_q != '0) begin
                            src_p <= src_q;
                            dst_p <= dst_q;
                            cnt   <= len_q;
                            done  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (m_gnt) begin
                        buffer <= m_rd;
                        src_p  <= src_p + AW'(4);
                    end
                end
                S_WR: begin
                    if (m_gnt) begin
                        dst_p <= dst_p + AW'(4);
                        cnt   <= cnt - LW'(1);
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: a reference model queues the expected bus writes of
// each programmed transfer, and a negedge monitor pops and checks every m_we cycle.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] dma_data_out;
    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic        irq;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;

    dma_engine dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .WE           (WE),
        .WD           (WD),
        .dma_data_out (dma_data_out),
        .m_req        (m_req),
        .m_gnt        (m_gnt),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_wd         (m_wd),
        .m_rd         (m_rd),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Read-only memory image: contents are a fixed hash of the byte address
    function automatic logic [31:0] bus_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign m_rd = bus_data(m_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_we) begin
            writes++;
            chk("we_needs_gnt", 32'(m_gnt), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", m_addr, m_wd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", m_addr, mon_e.addr);
                chk("wr_data", m_wd, mon_e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        A  = a;
        WE = 1'b1;
        WD = d;
        cyc();
        WE = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = dma_data_out;
    endtask

    // Reference model: word i copies mem[src+4i] to dst+4i, 32-bit wrapping addresses
    task automatic program_go(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] off;
        cpu_write(2'd0, src);
        cpu_write(2'd1, dst);
        cpu_write(2'd2, 32'(len));
        if (src[1:0] == 2'b00 && dst[1:0] == 2'b00) begin
            for (int i = 0; i < len; i++) begin
                off = 32'(i) * 32'd4;
                exp_q.push_back('{addr: dst + off, data: bus_data(src + off)});
            end
        end
        cpu_write(2'd3, 32'h1);
    endtask

    task automatic wait_done(input string name, input bit rand_gnt);
        logic [31:0] st;
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            read_reg(2'd3, st);
            if (st[1:0] == 2'b10) begin
                ok = 1'b1;
                break;
            end
            if (rand_gnt) m_gnt = ($urandom_range(9) < 7);
            cyc();
        end
        m_gnt = 1'b1;
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_writes(input int target);
        for (int i = 0; i < 40 && writes < target; i++) cyc();
        chk("wait_writes", 32'(writes), 32'(target));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] s;
        logic [31:0] d;
        int          base;
        int          len;

        rst = 1'b1; A = 2'd0; WE = 1'b0; WD = '0; m_gnt = 1'b0;
        cyc(); cyc();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wd", m_wd, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), rd);
            chk("rst_reg", rd, 32'd0);
        end
        rst = 1'b0;
        cyc();

        cpu_write(2'd2, 32'hABCD_1234);
        read_reg(2'd2, rd);
        chk("len_zero_ext", rd, 32'h0000_1234);

        // Basic copy with grant held: FIN after 7 edges past go, done after 8
        m_gnt = 1'b1;
        base  = writes;
        program_go(32'h10, 32'h40, 3);
        repeat (7) cyc();
        read_reg(2'd3, rd);
        chk("copy_fin_status", rd, 32'h1);
        chk("copy_fin_irq", 32'(irq), 32'd0);
        cyc();
        read_reg(2'd3, rd);
        chk("copy_done_status", rd, 32'h2);
        chk("copy_done_irq", 32'(irq), 32'd1);
        chk("copy_writes", 32'(writes - base), 32'd3);
        read_reg(2'd0, rd);
        chk("copy_src_readback", rd, 32'h10);

        // Zero length: straight to FIN, no bus request
        cpu_write(2'd3, 32'h2);
        program_go(32'h0, 32'h0, 0);
        chk("len0_no_req", 32'(m_req), 32'd0);
        read_reg(2'd3, rd);
        chk("len0_fin_status", rd, 32'h1);
        cyc();
        read_reg(2'd3, rd);
        chk("len0_done_status", rd, 32'h2);

        // clr_done landing in the FIN cycle loses to FIN's done
        cpu_write(2'd3, 32'h2);
        read_reg(2'd3, rd);
        chk("clr_status", rd, 32'h0);
        cpu_write(2'd3, 32'h1);
        cpu_write(2'd3, 32'h2);
        read_reg(2'd3, rd);
        chk("fin_clr_priority", rd, 32'h2);

        // Misaligned source: error, no bus activity
        base = writes;
        program_go(32'h12, 32'h40, 2);
        read_reg(2'd3, rd);
        chk("misalign_status", rd, 32'h6);
        chk("misalign_no_req", 32'(m_req), 32'd0);
        cyc();
        chk("misalign_no_req2", 32'(m_req), 32'd0);
        chk("misalign_no_wr", 32'(writes - base), 32'd0);
        cpu_write(2'd3, 32'h2);
        read_reg(2'd3, rd);
        chk("misalign_clr", rd, 32'h0);

        // Grant withdrawn for 5 cycles after word 1 of a 4-word copy
        base = writes;
        program_go(32'h1000, 32'h2000, 4);
        wait_writes(base + 1);
        m_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("gap_req_held", 32'(m_req), 32'd1);
            cyc();
        end
        m_gnt = 1'b1;
        wait_done("gap_done", 1'b0);
        chk("gap_writes", 32'(writes - base), 32'd4);

        // SRC write and second go while busy are ignored
        base = writes;
        program_go(32'h100, 32'h200, 3);
        cpu_write(2'd0, 32'hFFF0);
        cpu_write(2'd3, 32'h1);
        read_reg(2'd0, rd);
        chk("busy_src_kept", rd, 32'h100);
        wait_done("busy_done", 1'b0);
        chk("busy_writes", 32'(writes - base), 32'd3);

        // Address wrap through 2^32
        base = writes;
        program_go(32'hFFFF_FFF8, 32'hFFFF_FFF0, 4);
        wait_done("wrap_done", 1'b0);
        chk("wrap_writes", 32'(writes - base), 32'd4);

        // Randomized transfers with a flickering grant
        for (int t = 0; t < 16; t++) begin
            s    = $urandom() & 32'hFFFF_FFFC;
            d    = $urandom() & 32'hFFFF_FFFC;
            len  = $urandom_range(8, 1);
            base = writes;
            program_go(s, d, len);
            wait_done("rand_done", 1'b1);
            chk("rand_writes", 32'(writes - base), 32'(len));
            read_reg(2'd0, rd);
            chk("rand_src_readback", rd, s);
            read_reg(2'd1, rd);
            chk("rand_dst_readback", rd, d);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the write of word 2 aborts cleanly
        base = writes;
        program_go(32'h300, 32'h380, 3);
        wait_writes(base + 1);
        cyc();
        chk("pre_rst_we", 32'(m_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(m_we), 32'd0);
        chk("rst_mid_req", 32'(m_req), 32'd0);
        chk("rst_mid_addr", m_addr, 32'd0);
        chk("rst_mid_wd", m_wd, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        cyc();
        rst = 1'b0;
        exp_q.delete();
        read_reg(2'd3, rd);
        chk("rst_mid_status", rd, 32'h0);
        read_reg(2'd0, rd);
        chk("rst_mid_src", rd, 32'h0);
        base = writes;
        repeat (20) cyc();
        chk("rst_no_more_writes", 32'(writes - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
